uart_tx_sequencer: RTL and testbench

Transmit-side controller for the Nexys2 UART. It accepts one byte per request, builds an 11-bit frame (start, 8 data LSB-first, parity or mark, stop), and generates the bit-time-up (BTU) strobe from a baud divider. It shifts the frame out one bit per BTU and counts 11 BTUs to frame completion. It sits between the host-side register interface and the serial TX pin, and owns the baud timer, shift register and bit count for the transmitter.

---
 rtl/uart_tx_sequencer.sv | 113 +++++++++++
 tb/tb_uart_tx_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: frames one byte (start, 8 data LSB-first, parity/mark, stop),
// times each bit with a baud divider and shifts the frame out on tx.
module uart_tx_sequencer #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       pen,
  input  logic       ohel,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       btu
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  BIT_LAST  = 4'd10;

  // Odd/even parity over the data byte, or a mark bit when parity is disabled.
  function automatic logic parity_bit(input logic [7:0] d, input logic en, input logic odd);
    parity_bit = en ? ((^d) ^ odd) : 1'b1;
  endfunction

  state_e      state_q, state_d;
  logic [10:0] sr_q, sr_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        btu_q, btu_d;
  logic        bit_tick_s;

  assign bit_tick_s = (state_q == SEND) && (baud_q == BAUD_LAST);

  // Next-state logic; the shift register idles at all ones so tx reads mark.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    btu_d   = bit_tick_s;
    case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        bit_d  = 4'd0;
        if (tx_start) begin
          state_d = SEND;
          sr_d    = {1'b1, parity_bit(tx_data, pen, ohel), tx_data, 1'b0};
        end else begin
          state_d = IDLE;
          sr_d    = 11'h7FF;
        end
      end
      SEND: begin
        if (bit_tick_s) begin
          sr_d   = {1'b1, sr_q[10:1]};
          baud_d = 16'd0;
          if (bit_q == BIT_LAST) begin
            state_d = IDLE;
            bit_d   = 4'd0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        sr_d    = 11'h7FF;
        baud_d  = 16'd0;
        bit_d   = 4'd0;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any frame and returns the line to mark.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= 11'h7FF;
      baud_q  <= 16'd0;
      bit_q   <= 4'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      btu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      btu_q   <= btu_d;
    end
  end

  assign tx       = sr_q[0];
  assign tx_ready = ready_q;
  assign tx_done  = done_q;
  assign btu      = btu_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: two instances (divider 16 and 2) share stimulus,
// every cycle of each frame is compared against a frame/timing reference model.
module tb_uart_tx_sequencer;

  localparam int BD_A = 16;
  localparam int BD_B = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       pen = 1'b0;
  logic       ohel = 1'b0;

  logic a_tx, a_ready, a_done, a_btu;
  logic b_tx, b_ready, b_done, b_btu;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_sequencer #(.BAUD_DIV(BD_A)) dut_a (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data), .pen(pen), .ohel(ohel),
    .tx(a_tx), .tx_ready(a_ready), .tx_done(a_done), .btu(a_btu)
  );

  uart_tx_sequencer #(.BAUD_DIV(BD_B)) dut_b (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data), .pen(pen), .ohel(ohel),
    .tx(b_tx), .tx_ready(b_ready), .tx_done(b_done), .btu(b_btu)
  );

  task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  // Reference frame: bit n is what the line carries during bit time n.
  function automatic logic [10:0] ref_frame(input logic [7:0] d, input logic p, input logic o);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = p ? logic'((($countones(d) + int'(o)) % 2) != 0) : 1'b1;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic chk_idle(input string tag, input int t);
    chk({tag, "_a_tx"}, t, 32'(a_tx), 32'd1);
    chk({tag, "_a_ready"}, t, 32'(a_ready), 32'd1);
    chk({tag, "_a_done"}, t, 32'(a_done), 32'd0);
    chk({tag, "_a_btu"}, t, 32'(a_btu), 32'd0);
    chk({tag, "_b_tx"}, t, 32'(b_tx), 32'd1);
    chk({tag, "_b_ready"}, t, 32'(b_ready), 32'd1);
    chk({tag, "_b_done"}, t, 32'(b_done), 32'd0);
    chk({tag, "_b_btu"}, t, 32'(b_btu), 32'd0);
  endtask

  // Called at a falling edge; the request is accepted at the next rising edge (t=0 after it).
  // With hold=1 tx_start stays high throughout and on return.
  task automatic frame(input int bd, input logic [7:0] d, input logic p, input logic o, input bit hold);
    logic [10:0] f;
    logic otx, ordy, odone, obtu;
    f = ref_frame(d, p, o);
    tx_start = 1'b1;
    tx_data  = d;
    pen      = p;
    ohel     = o;
    for (int t = 0; t <= 11 * bd; t++) begin
      @(negedge clk);
      if (bd == BD_A) begin
        otx = a_tx; ordy = a_ready; odone = a_done; obtu = a_btu;
      end else begin
        otx = b_tx; ordy = b_ready; odone = b_done; obtu = b_btu;
      end
      chk("tx", t, 32'(otx), (t < 11 * bd) ? 32'(f[t / bd]) : 32'd1);
      chk("tx_ready", t, 32'(ordy), (t == 11 * bd) ? 32'd1 : 32'd0);
      chk("tx_done", t, 32'(odone), (t == 11 * bd) ? 32'd1 : 32'd0);
      chk("btu", t, 32'(obtu), (t > 0 && (t % bd) == 0) ? 32'd1 : 32'd0);
      if (t == 0) begin
        tx_start = hold;
        tx_data  = 8'($urandom);
        pen      = 1'($urandom);
        ohel     = 1'($urandom);
      end
    end
  endtask

  initial begin
    // Reset held, then released with no requests
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle("rst", i);
    end
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk_idle("idle", i);
    end

    // Directed frames on the divide-by-16 instance
    frame(BD_A, 8'h55, 1'b1, 1'b0, 1'b0);
    frame(BD_A, 8'h55, 1'b1, 1'b1, 1'b0);
    frame(BD_A, 8'h80, 1'b0, 1'b0, 1'b0);
    frame(BD_A, 8'hA3, 1'b1, 1'b0, 1'b1);
    frame(BD_A, 8'h3C, 1'b1, 1'b1, 1'b0);

    // Reset during bit 4 of a 0xFF frame
    tx_start = 1'b1;
    tx_data  = 8'hFF;
    pen      = 1'b1;
    ohel     = 1'b0;
    @(negedge clk);
    tx_start = 1'b0;
    for (int t = 1; t <= 4 * BD_A + 3; t++) @(negedge clk);
    chk("pre_rst_tx", 0, 32'(a_tx), 32'd1);
    chk("pre_rst_ready", 0, 32'(a_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("async_rst_tx", 0, 32'(a_tx), 32'd1);
    chk("async_rst_ready", 0, 32'(a_ready), 32'd1);
    chk("async_rst_done", 0, 32'(a_done), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk_idle("rst_hold", i);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("post_rst", i);
    end
    frame(BD_A, 8'h0F, 1'b1, 1'b0, 1'b0);

    // Randomized frames on divide-by-16, some back-to-back
    for (int n = 0; n < 6; n++) begin
      frame(BD_A, 8'($urandom), 1'($urandom), 1'($urandom), (n < 5) ? 1'($urandom) : 1'b0);
    end

    // Minimum divider instance; the other instance is busy but unchecked from here on
    frame(BD_B, 8'h01, 1'b0, 1'b0, 1'b0);
    frame(BD_B, 8'hC5, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 10; n++) begin
      frame(BD_B, 8'($urandom), 1'($urandom), 1'($urandom), (n < 9) ? 1'($urandom) : 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b_idle_tx", i, 32'(b_tx), 32'd1);
      chk("b_idle_ready", i, 32'(b_ready), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
